// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sample RAM with a masked trigger, a programmable
// pre-trigger depth and a time-ordered readout port for the control side.
module la_capture_core #(
    parameter int unsigned DATA_W = 52,
    parameter int unsigned TRIG_W = 4,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_value_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [2:0]        state_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StWait = 3'd2,
        StPost = 3'd3,
        StDone = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ModeEq   = 2'd0,
        ModeNeq  = 2'd1,
        ModeRise = 2'd2,
        ModeImm  = 2'd3
    } mode_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] OneAddr  = ADDR_W'(1);

    state_e              r_state;
    state_e              w_state_next;

    logic [1:0]          r_mode;
    logic [TRIG_W-1:0]   r_mask;
    logic [TRIG_W-1:0]   r_value;
    logic [ADDR_W-1:0]   r_pretrig;
    logic [TRIG_W-1:0]   r_trig_prev;

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic [ADDR_W-1:0]   r_trig_addr;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;

    logic                w_arm;
    logic                w_eq;
    logic                w_cond;
    logic                w_trig_hit;
    logic [ADDR_W-1:0]   w_post_len;
    logic [ADDR_W-1:0]   w_rd_phys;
    logic                w_write_en;
    logic                w_rd_fire;
    logic                w_done;

    // Abort outranks arm in every state.
    assign w_arm      = arm_i && !abort_i;
    assign w_post_len = LastAddr - r_pretrig;
    assign w_rd_phys  = r_trig_addr - r_pretrig + rd_addr_i;

    // Trigger condition, evaluated against the same-cycle trig_i.
    always_comb begin
        w_eq   = ((trig_i & r_mask) == (r_value & r_mask));
        w_cond = 1'b0;
        unique case (mode_e'(r_mode))
            ModeEq:   w_cond = w_eq;
            ModeNeq:  w_cond = !w_eq;
            ModeRise: w_cond = |(trig_i & ~r_trig_prev & r_mask);
            ModeImm:  w_cond = 1'b1;
        endcase
    end

    assign w_trig_hit = (r_state == StWait) && w_cond;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        if (abort_i) begin
            w_state_next = StIdle;
        end else if (arm_i) begin
            w_state_next = (pretrig_i == '0) ? StWait : StPre;
        end else begin
            case (r_state)
                StPre: begin
                    if (r_cnt == r_pretrig - OneAddr) begin
                        w_state_next = StWait;
                    end
                end
                StWait: begin
                    if (w_cond) begin
                        w_state_next = (w_post_len == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (r_post_cnt == OneAddr) begin
                        w_state_next = StDone;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        w_write_en = 1'b0;
        w_done     = 1'b0;
        w_rd_fire  = 1'b0;
        if (!abort_i && !arm_i) begin
            w_write_en = (r_state == StPre) || (r_state == StWait) || (r_state == StPost);
        end
        if (r_state == StDone) begin
            w_done    = 1'b1;
            w_rd_fire = rd_en_i;
        end
    end

    // Config latch, write pointer and capture counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode      <= '0;
            r_mask      <= '0;
            r_value     <= '0;
            r_pretrig   <= '0;
            r_trig_prev <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
        end else begin
            r_trig_prev <= trig_i;
            if (w_arm) begin
                r_mode    <= trig_mode_i;
                r_mask    <= trig_mask_i;
                r_value   <= trig_value_i;
                r_pretrig <= pretrig_i;
                r_wr_ptr  <= '0;
                r_cnt     <= '0;
            end else if (w_write_en) begin
                r_wr_ptr <= r_wr_ptr + OneAddr;
                if (r_state == StPre) begin
                    r_cnt <= r_cnt + OneAddr;
                end
                if (w_trig_hit) begin
                    r_trig_addr <= r_wr_ptr;
                    r_post_cnt  <= w_post_len;
                end
                if (r_state == StPost) begin
                    r_post_cnt <= r_post_cnt - OneAddr;
                end
            end
        end
    end

    // Sample RAM write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (w_write_en) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Registered read port; data holds when no read is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= r_mem[w_rd_phys];
            end
        end
    end

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign state_o     = r_state;
    assign trig_addr_o = r_trig_addr;
    assign done_o      = w_done;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (DATA_W=8, TRIG_W=4, DEPTH=16); data_i is a cycle counter.
module tb_la_capture_core;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] data_i;
    logic [3:0] trig_i;
    logic       arm_i;
    logic       abort_i;
    logic [1:0] trig_mode_i;
    logic [3:0] trig_mask_i;
    logic [3:0] trig_value_i;
    logic [3:0] pretrig_i;
    logic       rd_en_i;
    logic [3:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic [2:0] state_o;
    logic [3:0] trig_addr_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] a_base;
    logic [7:0] b_base;

    la_capture_core #(
        .DATA_W(8),
        .TRIG_W(4),
        .DEPTH (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .trig_i      (trig_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .trig_mode_i (trig_mode_i),
        .trig_mask_i (trig_mask_i),
        .trig_value_i(trig_value_i),
        .pretrig_i   (pretrig_i),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .state_o     (state_o),
        .trig_addr_o (trig_addr_o),
        .done_o      (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs settle, then the sample counter advances.
    task automatic tick();
        @(posedge clk_i);
        #1;
        data_i = data_i + 8'd1;
    endtask

    function automatic logic [7:0] smp(input logic [7:0] base, input int off);
        return base + 8'(off);
    endfunction

    task automatic arm(input logic [1:0] mode, input logic [3:0] mask,
                       input logic [3:0] value, input logic [3:0] pre);
        trig_mode_i  = mode;
        trig_mask_i  = mask;
        trig_value_i = value;
        pretrig_i    = pre;
        arm_i        = 1'b1;
        tick();
        arm_i        = 1'b0;
        // Scramble config inputs: the latched copy must be used.
        trig_mode_i  = ~mode;
        trig_mask_i  = ~mask;
        trig_value_i = ~value;
        pretrig_i    = ~pre;
    endtask

    task automatic rd(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        rd_en_i   = 1'b1;
        rd_addr_i = addr;
        tick();
        rd_en_i   = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
        chk(tag, 32'(rd_data_o), 32'(exp));
    endtask

    initial begin
        rst_i = 1'b1; data_i = 8'd0; trig_i = 4'd0; arm_i = 1'b0; abort_i = 1'b0;
        trig_mode_i = 2'd0; trig_mask_i = 4'd0; trig_value_i = 4'd0; pretrig_i = 4'd0;
        rd_en_i = 1'b0; rd_addr_i = 4'd0;
        repeat (3) tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_rdata", 32'(rd_data_o), 32'd0);
        chk("rst_taddr", 32'(trig_addr_o), 32'd0);
        rst_i = 1'b0;

        // 1: EQ 5, pretrig 4, trigger on sample 20.
        for (int i = 0; i < 64 && data_i != 8'd15; i++) tick();
        chk("t1_sync", 32'(data_i), 32'd15);
        arm(2'd0, 4'hF, 4'h5, 4'd4);
        chk("t1_pre", 32'(state_o), 32'd1);
        repeat (4) tick();
        chk("t1_wait", 32'(state_o), 32'd2);
        trig_i = 4'h5;
        tick();
        trig_i = 4'h0;
        chk("t1_post", 32'(state_o), 32'd3);
        chk("t1_taddr", 32'(trig_addr_o), 32'd4);
        repeat (10) tick();
        chk("t1_post_last", 32'(state_o), 32'd3);
        tick();
        chk("t1_done_state", 32'(state_o), 32'd4);
        chk("t1_done", 32'(done_o), 32'd1);
        rd_en_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr_i = 4'(i);
            tick();
            chk("t1_rd_valid", 32'(rd_valid_o), 32'd1);
            chk("t1_rd_data", 32'(rd_data_o), 32'(16 + i));
        end
        rd_en_i = 1'b0;
        tick();
        chk("t1_rd_idle_valid", 32'(rd_valid_o), 32'd0);
        chk("t1_rd_hold", 32'(rd_data_o), 32'd31);

        // 2: IMMEDIATE, pretrig 0.
        a_base = data_i;
        arm(2'd3, 4'h0, 4'h0, 4'd0);
        chk("t2_wait", 32'(state_o), 32'd2);
        tick();
        chk("t2_post", 32'(state_o), 32'd3);
        chk("t2_taddr", 32'(trig_addr_o), 32'd0);
        repeat (14) tick();
        chk("t2_post_last", 32'(state_o), 32'd3);
        tick();
        chk("t2_done", 32'(state_o), 32'd4);
        rd("t2_rd0", 4'd0, smp(a_base, 1));
        rd("t2_rd15", 4'd15, smp(a_base, 16));

        // 3: EQ with matching trig_i held through PRE, pretrig 6.
        trig_i = 4'h5;
        a_base = data_i;
        arm(2'd0, 4'hF, 4'h5, 4'd6);
        repeat (5) tick();
        chk("t3_still_pre", 32'(state_o), 32'd1);
        tick();
        chk("t3_wait", 32'(state_o), 32'd2);
        tick();
        trig_i = 4'h0;
        chk("t3_post", 32'(state_o), 32'd3);
        chk("t3_taddr", 32'(trig_addr_o), 32'd6);
        repeat (9) tick();
        chk("t3_done", 32'(state_o), 32'd4);
        rd("t3_rd6", 4'd6, smp(a_base, 7));
        rd("t3_rd0", 4'd0, smp(a_base, 1));

        // 4: RISE on bit 1 only.
        trig_i = 4'b0010;
        arm(2'd2, 4'b0010, 4'h0, 4'd0);
        repeat (3) tick();
        trig_i = 4'b0001; tick();
        trig_i = 4'b0000; tick();
        trig_i = 4'b0001; tick();
        trig_i = 4'b0000; tick();
        chk("t4_no_rise", 32'(state_o), 32'd2);
        trig_i = 4'b0010;
        b_base = data_i;
        tick();
        chk("t4_rise", 32'(state_o), 32'd3);
        chk("t4_taddr", 32'(trig_addr_o), 32'd7);
        trig_i = 4'b0000;
        repeat (15) tick();
        chk("t4_done", 32'(state_o), 32'd4);
        rd("t4_rd0", 4'd0, b_base);
        rd("t4_rd15", 4'd15, smp(b_base, 15));

        // 5: abort with arm in WAIT.
        arm(2'd0, 4'hF, 4'h5, 4'd0);
        chk("t5_wait", 32'(state_o), 32'd2);
        arm_i = 1'b1; abort_i = 1'b1;
        tick();
        arm_i = 1'b0; abort_i = 1'b0;
        chk("t5_idle", 32'(state_o), 32'd0);
        chk("t5_done", 32'(done_o), 32'd0);
        rd_en_i = 1'b1; rd_addr_i = 4'd3;
        tick();
        rd_en_i = 1'b0;
        chk("t5_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("t5_rd_hold", 32'(rd_data_o), 32'(smp(b_base, 15)));

        // 6: async reset during POST, then a clean capture.
        arm(2'd3, 4'h0, 4'h0, 4'd3);
        repeat (4) tick();
        chk("t6_post", 32'(state_o), 32'd3);
        chk("t6_taddr", 32'(trig_addr_o), 32'd3);
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_state", 32'(state_o), 32'd0);
        chk("t6_rst_done", 32'(done_o), 32'd0);
        chk("t6_rst_taddr", 32'(trig_addr_o), 32'd0);
        chk("t6_rst_rdata", 32'(rd_data_o), 32'd0);
        chk("t6_rst_valid", 32'(rd_valid_o), 32'd0);
        tick();
        rst_i = 1'b0;
        a_base = data_i;
        arm(2'd3, 4'h0, 4'h0, 4'd2);
        repeat (3) tick();
        chk("t6_rearm_post", 32'(state_o), 32'd3);
        chk("t6_rearm_taddr", 32'(trig_addr_o), 32'd2);
        repeat (12) tick();
        chk("t6_rearm_post_last", 32'(state_o), 32'd3);
        tick();
        chk("t6_rearm_done", 32'(state_o), 32'd4);
        rd("t6_rd0", 4'd0, smp(a_base, 1));
        rd("t6_rd2", 4'd2, smp(a_base, 3));
        rd("t6_rd15", 4'd15, smp(a_base, 16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
